// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: walks rs1 over a programmable address range, reading
// r[rs1] and r[rs1+STRIDE], running them through an external ALU and writing
// the result back to r[rs1+STRIDE]. Free-run (delayed) or single-step mode.
// Optional feature macro: SEQ_CARRY_STICKY_EN (sticky ALU carry flag).
module regfile_op_sequencer #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned STRIDE       = 1,
    parameter int unsigned DELAY_CYCLES = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic              mode_in,
    input  logic [3:0]        alu_op_in,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic [ADDR_W-1:0] rs1,
    output logic [ADDR_W-1:0] rs2,
    output logic [ADDR_W-1:0] rd,
    output logic              reg_write,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic              busy,
    output logic              done,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic [ADDR_W:0]   op_count,
    output logic              carry_sticky
);

    localparam int unsigned       CNT_W    = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_FETCH,
        S_EXEC,
        S_STORE,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   rs2_q, rs2_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic                mode_q, mode_d;
    logic [3:0]          alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [DATA_W-1:0]   disp_data_q, disp_data_d;
    logic [ADDR_W:0]     op_count_q, op_count_d;
    logic                reg_write_q, reg_write_d;
    logic                disp_valid_q, disp_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef SEQ_CARRY_STICKY_EN
    logic                sticky_q, sticky_d;
`else
    logic                unused_carry;
    assign unused_carry = alu_carry;
`endif

    // Next-state and next-output computation; pulse outputs follow the next state
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        rs2_d        = rs2_q;
        end_d        = end_q;
        mode_d       = mode_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        wr_data_d    = wr_data_q;
        disp_data_d  = disp_data_q;
        op_count_d   = op_count_q;
        reg_write_d  = 1'b0;
        disp_valid_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
`ifdef SEQ_CARRY_STICKY_EN
        sticky_d     = sticky_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_WAIT;
                    addr_d     = start_addr;
                    end_d      = end_addr;
                    mode_d     = mode_in;
                    alu_op_d   = alu_op_in;
                    op_count_d = '0;
                    cnt_d      = '0;
`ifdef SEQ_CARRY_STICKY_EN
                    sticky_d   = 1'b0;
`endif
                end
            end
            S_WAIT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (mode_q) begin
                    if (step) begin
                        state_d = S_FETCH;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FETCH: begin
                alu_a_d = rd_data1;
                alu_b_d = rd_data2;
                state_d = stop ? S_IDLE : S_EXEC;
            end
            S_EXEC: begin
                wr_data_d = alu_result;
`ifdef SEQ_CARRY_STICKY_EN
                if (alu_carry) begin
                    sticky_d = 1'b1;
                end
`endif
                state_d = stop ? S_IDLE : S_STORE;
            end
            S_STORE: begin
                // The write is already on the bus this cycle; stop only skips ADVANCE
                state_d = stop ? S_IDLE : S_ADVANCE;
            end
            S_ADVANCE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (addr_q == end_q) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != S_IDLE) begin
            rs2_d = addr_d + STRIDE_A;
        end

        if (state_d == S_STORE) begin
            reg_write_d  = 1'b1;
            disp_valid_d = 1'b1;
            disp_data_d  = wr_data_d;
            op_count_d   = op_count_q + 1'b1;
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            rs2_q        <= '0;
            end_q        <= '0;
            mode_q       <= 1'b0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            wr_data_q    <= '0;
            disp_data_q  <= '0;
            op_count_q   <= '0;
            reg_write_q  <= 1'b0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SEQ_CARRY_STICKY_EN
            sticky_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            rs2_q        <= rs2_d;
            end_q        <= end_d;
            mode_q       <= mode_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            wr_data_q    <= wr_data_d;
            disp_data_q  <= disp_data_d;
            op_count_q   <= op_count_d;
            reg_write_q  <= reg_write_d;
            disp_valid_q <= disp_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SEQ_CARRY_STICKY_EN
            sticky_q     <= sticky_d;
`endif
        end
    end

    assign rs1        = addr_q;
    assign rs2        = rs2_q;
    assign rd         = rs2_q;
    assign reg_write  = reg_write_q;
    assign wr_data    = wr_data_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign op_count   = op_count_q;
`ifdef SEQ_CARRY_STICKY_EN
    assign carry_sticky = sticky_q;
`else
    assign carry_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Testbench for regfile_op_sequencer: register file and ALU environment plus a
// queue-based reference model of the expected write-back sequence.
module tb_regfile_op_sequencer;

    localparam int unsigned DW   = 64;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;
    localparam int unsigned DLY  = 4;

    logic          clk = 1'b0;
    logic          rst, start, stop, step, mode_in;
    logic [3:0]    alu_op_in;
    logic [AW-1:0] start_addr, end_addr;
    logic [DW-1:0] rd_data1, rd_data2, alu_result;
    logic          alu_carry;
    logic [AW-1:0] rs1, rs2, rd;
    logic          reg_write;
    logic [DW-1:0] wr_data, alu_a, alu_b, disp_data;
    logic [3:0]    alu_op;
    logic          busy, done, disp_valid, carry_sticky;
    logic [AW:0]   op_count;

    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] rf [NREG];
    logic [DW-1:0] m  [NREG];

    typedef struct {
        logic [AW-1:0] rs1;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q [$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int step_cyc = 0;
    bit chk_gap = 1'b0;
    bit exp_sticky = 1'b0;
    logic [DW-1:0] last_data = '0;

    always #5 clk = ~clk;

    regfile_op_sequencer #(
        .DATA_W(DW), .ADDR_W(AW), .STRIDE(1), .DELAY_CYCLES(DLY)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
        .mode_in(mode_in), .alu_op_in(alu_op_in),
        .start_addr(start_addr), .end_addr(end_addr),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write),
        .wr_data(wr_data), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .busy(busy), .done(done), .disp_valid(disp_valid),
        .disp_data(disp_data), .op_count(op_count), .carry_sticky(carry_sticky)
    );

    // Environment ALU: carry is add carry-out or subtract borrow
    function automatic logic [DW:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a} - {1'b0, b};
            4'd2:    return {1'b0, a & b};
            4'd3:    return {1'b0, a | b};
            4'd4:    return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    assign {alu_carry, alu_result} = alu_f(alu_op, alu_a, alu_b);
    assign rd_data1 = rf[rs1];
    assign rd_data2 = rf[rs2];

    // Register file: bench preload port has priority over the DUT write port
    always @(posedge clk) begin
        if (ld_en) rf[ld_addr] <= ld_data;
        else if (reg_write) rf[rd] <= wr_data;
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Advance one cycle, sample at the falling edge and score any write-back
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (reg_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 64'(rd), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_rs1", 64'(rs1), 64'(e.rs1));
                check_eq("wr_rd", 64'(rd), 64'(e.rd));
                check_eq("wr_rs2", 64'(rs2), 64'(e.rd));
                check_eq("wr_data", wr_data, e.data);
                check_eq("disp_valid", 64'(disp_valid), 64'd1);
                check_eq("disp_data", disp_data, e.data);
            end
            if (chk_gap && wr_cnt > 0) check_eq("wr_gap", 64'(cyc - last_wr_cyc), 64'(DLY + 4));
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic load_reg(input int a, input logic [DW-1:0] v);
        ld_en = 1'b1; ld_addr = AW'(a); ld_data = v; m[a] = v;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic load_random();
        for (int i = 0; i < int'(NREG); i++) load_reg(i, {$urandom, $urandom});
    endtask

    // Reference: up to nmax ops of the run, computed on the model register file
    task automatic plan(input int sa, input int ea, input logic [3:0] op, input int nmax);
        int n, a, d;
        logic [DW:0] r;
        n = ((ea - sa) & (NREG - 1)) + 1;
        exp_sticky = 1'b0;
        for (int k = 0; k < n && k < nmax; k++) begin
            a = (sa + k) % NREG;
            d = (a + 1) % NREG;
            r = alu_f(op, m[a], m[d]);
            if (r[DW]) exp_sticky = 1'b1;
            m[d] = r[DW-1:0];
            last_data = r[DW-1:0];
            exp_q.push_back('{rs1: AW'(a), rd: AW'(d), data: r[DW-1:0]});
        end
    endtask

    task automatic start_run(input int sa, input int ea, input logic [3:0] op, input logic md, input bit gap);
        start_addr = AW'(sa); end_addr = AW'(ea); alu_op_in = op; mode_in = md;
        chk_gap = gap; wr_cnt = 0; done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (done_cnt == 0 && i < budget) begin
            tick();
            i++;
        end
        if (done_cnt == 0) check_eq("done_timeout", 64'd0, 64'd1);
        tick();
    endtask

    task automatic end_checks(input int nops);
        check_eq("op_count", 64'(op_count), 64'(nops));
        check_eq("busy_after", 64'(busy), 64'd0);
        check_eq("done_once", 64'(done_cnt), 64'd1);
        check_eq("all_writes_seen", 64'(exp_q.size()), 64'd0);
        check_eq("disp_hold", disp_data, last_data);
`ifdef SEQ_CARRY_STICKY_EN
        check_eq("carry_sticky", 64'(carry_sticky), 64'(exp_sticky));
`else
        check_eq("carry_sticky", 64'(carry_sticky), 64'd0);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_reg_write"}, 64'(reg_write), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_disp_valid"}, 64'(disp_valid), 64'd0);
        check_eq({tag, "_disp_data"}, disp_data, 64'd0);
        check_eq({tag, "_op_count"}, 64'(op_count), 64'd0);
        check_eq({tag, "_addr"}, 64'({rs1, rs2, rd}), 64'd0);
        check_eq({tag, "_wr_data"}, wr_data, 64'd0);
        check_eq({tag, "_alu_ab"}, alu_a | alu_b, 64'd0);
        check_eq({tag, "_alu_op"}, 64'(alu_op), 64'd0);
        check_eq({tag, "_sticky"}, 64'(carry_sticky), 64'd0);
    endtask

    initial begin
        logic [3:0] op;
        int sa, len;
        rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; mode_in = 1'b0;
        alu_op_in = '0; start_addr = '0; end_addr = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        load_random();

        // Free-run ADD accumulating chain over 0..2
        load_reg(0, 64'd1); load_reg(1, 64'd2); load_reg(2, 64'd3); load_reg(3, 64'd4);
        plan(0, 2, 4'd0, 99);
        start_run(0, 2, 4'd0, 1'b0, 1'b1);
        check_eq("busy_running", 64'(busy), 64'd1);
        wait_done(200);
        end_checks(3);
        check_eq("chain_r1", rf[1], 64'd3);
        check_eq("chain_r2", rf[2], 64'd6);
        check_eq("chain_r3", rf[3], 64'd10);

        // Single step, one-op range 5..5
        plan(5, 5, 4'd1, 99);
        start_run(5, 5, 4'd1, 1'b1, 1'b0);
        repeat (10) tick();
        check_eq("step_no_write", 64'(wr_cnt), 64'd0);
        step = 1'b1;
        step_cyc = cyc;
        tick();
        step = 1'b0;
        wait_done(50);
        check_eq("step_latency", 64'(last_wr_cyc - step_cyc), 64'd3);
        end_checks(1);

        // Wrap-around range 30..1
        op = 4'($urandom_range(0, 4));
        plan(30, 1, op, 99);
        start_run(30, 1, op, 1'b0, 1'b1);
        wait_done(300);
        end_checks(4);

        // stop in WAIT of the second op
        op = 4'($urandom_range(0, 4));
        plan(0, 3, op, 1);
        start_run(0, 3, op, 1'b0, 1'b1);
        for (int i = 0; i < 50 && wr_cnt == 0; i++) tick();
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("stop_wait_busy", 64'(busy), 64'd0);
        repeat (40) tick();
        check_eq("stop_wait_writes", 64'(wr_cnt), 64'd1);
        check_eq("stop_wait_done", 64'(done_cnt), 64'd0);
        check_eq("stop_wait_count", 64'(op_count), 64'd1);

        // stop in STORE: that write still lands
        op = 4'($urandom_range(0, 4));
        plan(0, 3, op, 1);
        start_run(0, 3, op, 1'b0, 1'b1);
        for (int i = 0; i < 50 && wr_cnt == 0; i++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("stop_store_busy", 64'(busy), 64'd0);
        repeat (40) tick();
        check_eq("stop_store_writes", 64'(wr_cnt), 64'd1);
        check_eq("stop_store_done", 64'(done_cnt), 64'd0);
        check_eq("stop_store_q", 64'(exp_q.size()), 64'd0);

        // Reset while in EXEC (step mode makes the timing exact)
        start_run(4, 4, 4'd0, 1'b1, 1'b0);
        repeat (3) tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("mid_rst");
        repeat (20) tick();
        check_eq("mid_rst_writes", 64'(wr_cnt), 64'd0);

        // start while busy is ignored
        op = 4'($urandom_range(0, 4));
        plan(10, 11, op, 99);
        start_run(10, 11, op, 1'b0, 1'b1);
        repeat (3) tick();
        start_addr = AW'(20); end_addr = AW'(25); start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200);
        end_checks(2);

        // Carry capture, then cleared by the next start (start beats stop in IDLE)
        load_reg(0, 64'hFFFF_FFFF_FFFF_FFFF); load_reg(1, 64'd1);
        plan(0, 0, 4'd0, 99);
        start_run(0, 0, 4'd0, 1'b0, 1'b0);
        wait_done(100);
        end_checks(1);
        load_reg(2, 64'd0); load_reg(3, 64'd0);
        plan(2, 2, 4'd0, 99);
        stop = 1'b1;
        start_run(2, 2, 4'd0, 1'b0, 1'b0);
        stop = 1'b0;
        check_eq("start_wins_busy", 64'(busy), 64'd1);
        check_eq("sticky_cleared", 64'(carry_sticky), 64'd0);
        wait_done(100);
        end_checks(1);

        // Randomized runs
        repeat (6) begin
            load_random();
            sa  = $urandom_range(0, NREG - 1);
            len = $urandom_range(0, 3);
            op  = 4'($urandom_range(0, 5));
            plan(sa, (sa + len) % NREG, op, 99);
            start_run(sa, (sa + len) % NREG, op, 1'b0, 1'b1);
            wait_done(300);
            end_checks(len + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Parametrised successor to the fixed "add r[n] + r[n+1] -> r[n+1]" demo controller.
- Sequences register-file read, ALU operation and write-back over a programmable address range, with selectable ALU op, stride, and free-run or single-step mode.
- Drives the register-file read/write ports and the ALU operand/op inputs, and presents each result to the LED display logic.

Parameters:
- DATA_W, 64, operand/result width.
- ADDR_W, 5, register address width (2^ADDR_W registers).
- STRIDE, 1, distance between rs1 and rs2/rd, modulo 2^ADDR_W.
- DELAY_CYCLES, 100000000, free-run wait cycles before each op; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a run; sampled only in IDLE
- stop  in  1  abort request; sampled in every non-IDLE state
- step  in  1  one-cycle pulse; advances one op in step mode
- mode_in  in  1  0 = free-run with delay, 1 = single-step
- alu_op_in  in  4  ALU op code, latched at start
- start_addr  in  ADDR_W  first rs1, latched at start
- end_addr  in  ADDR_W  last rs1, latched at start
- rd_data1, rd_data2  in  DATA_W  register-file read data (combinational read)
- alu_result  in  DATA_W  ALU result
- alu_carry  in  1  ALU carry out
- rs1, rs2, rd  out  ADDR_W  register-file addresses; rd == rs2
- reg_write  out  1  register-file write enable
- wr_data  out  DATA_W  write-back data
- alu_a, alu_b  out  DATA_W  registered ALU operands
- alu_op  out  4  latched ALU op
- busy  out  1  high in any state other than IDLE/DONE
- done  out  1  one-cycle pulse on entry to DONE
- disp_valid  out  1  one-cycle pulse per stored result
- disp_data  out  DATA_W  last stored result, held
- op_count  out  ADDR_W+1  completed write-backs in the current run
- carry_sticky  out  1  see Optional Feature

Behaviour:
- All outputs are registered. Reset value is 0 for every output.
- Reset forces IDLE and clears the delay counter, address, op regs and op_count.
- States: IDLE, WAIT, FETCH, EXEC, STORE, ADVANCE, DONE.
- IDLE:
  - On start=1, latch start_addr, end_addr, alu_op_in and mode_in.
  - Set addr := start_addr and clear op_count and carry_sticky.
  - Next state is WAIT.
- WAIT, mode 0: count DELAY_CYCLES cycles, then go to FETCH. The counter restarts from 0 on each WAIT entry.
- WAIT, mode 1: stay until step=1, then go to FETCH. step outside WAIT is ignored.
- rs1 = addr and rs2 = rd = (addr + STRIDE) mod 2^ADDR_W; both are valid from WAIT onward.
- FETCH (1 cycle): alu_a := rd_data1 and alu_b := rd_data2 at the end of the cycle.
- EXEC (1 cycle): ALU is combinational on alu_a/alu_b. Capture wr_data := alu_result and the carry.
- STORE (1 cycle):
  - reg_write=1, writing wr_data to rd.
  - disp_valid=1, disp_data := wr_data, op_count += 1.
- ADVANCE:
  - If addr == end_addr, go to DONE.
  - Otherwise addr := addr + 1 (wraps at 2^ADDR_W) and go to WAIT.
- Run length:
  - Ops per run = ((end_addr - start_addr) mod 2^ADDR_W) + 1.
  - start_addr == end_addr gives exactly 1 op.
  - start_addr > end_addr wraps through 0.
- DONE: done pulses for 1 cycle, then IDLE next cycle. op_count and disp_data hold until the next start.
- Latency per op:
  - Free-run: DELAY_CYCLES + 4 cycles from WAIT entry to ADVANCE.
  - Step mode: the write occurs 3 cycles after the step pulse.
- stop:
  - In WAIT, FETCH, EXEC or ADVANCE: go to IDLE next cycle with no write and no done.
  - In STORE: the write completes this cycle, then IDLE.
- start while busy is ignored. start and stop together in IDLE: start wins.
- rst mid-run: no reg_write is issued on the reset cycle or afterwards; all state is cleared.
- A write to rd becomes visible to the next op's FETCH. With STRIDE=1, r[n+1] updated by op n is read as rs1 of op n+1 (accumulating chain).

Optional Feature:
- Macro: SEQ_CARRY_STICKY_EN.
- Defined:
  - carry_sticky is set in EXEC when alu_carry=1 and is cleared at start.
  - It holds through DONE. Reset clears it.
- Undefined: carry_sticky tied to 0 and no carry capture logic.

Test Plan:
- Free-run:
  - Setup: DELAY_CYCLES=4, mode 0, ADD, range 0..2; r0=1, r1=2, r2=3, r3=4.
  - Expected: writes r1=3, r2=6, r3=10; op_count=3; done pulses once; 8 cycles between reg_write pulses.
- Step mode, start_addr=end_addr=5:
  - Expected: no write until step; reg_write exactly 3 cycles after step; op_count=1.
- Wrap-around, ADDR_W=5, range 30..1:
  - Expected: 4 ops on rs1=30,31,0,1 with rd=31,0,1,2.
- stop:
  - stop during WAIT of op 2: no second write, busy low next cycle, done never asserted.
  - stop during STORE: the write occurs, then IDLE.
- Reset and start filtering:
  - rst asserted in EXEC: no reg_write afterwards; all outputs 0 next cycle.
  - start pulsed while busy: ignored.
- SEQ_CARRY_STICKY_EN:
  - Stimulus: r0=2^64-1, r1=1, ADD.
  - Expected: carry_sticky=1 after EXEC; still 1 at DONE; 0 after the next start.
